// File: rtl/game_turn_ctrl.sv
// game_turn_ctrl -- turn sequencer for a two-player ship-placement / shooting game.
//
// The boards live in an external memory. This block addresses that memory
// (board_sel/board_pos), reads a cell back through cell_state one cycle later,
// and issues clear and write strobes. It also keeps the placement counter, the
// per-player hit counters and the winner.
//
// Parameter:
//   SHIPS         ship cells placed by each player (1..15)
//
// Compile-time option:
//   HIT_BONUS_EN  when defined, a hit returns the turn to the same shooter;
//                 when undefined, the turn alternates after every valid shot
//
// Ports:
//   clk, rst         clock (rising edge) and asynchronous active-high reset
//   start            pulse: new game from IDLE or GAME_OVER
//   click_host/guest click pulses; cursor_host/guest cell {row[5:3], col[2:0]}
//   cell_state       readback of board_pos on board_sel (1-cycle latency)
//                    00 empty, 01 ship, 10 hit, 11 miss
//   board_clr        pulse: clear both boards
//   board_sel        0 host board, 1 guest board
//   board_pos        addressed cell
//   board_wr         write strobe, board_wdata is the written code
//   phase            state encoding (see table)
//   hits_host/guest  hits scored by each player
//   winner           00 none, 01 host, 10 guest
//
// State table:
//   state        | code | meaning
//   IDLE         |  0   | after reset, waits for start
//   PLACE_HOST   |  1   | host places ships on own board
//   PLACE_GUEST  |  2   | guest places ships on own board
//   TURN_HOST    |  3   | host shoots at guest board
//   TURN_GUEST   |  4   | guest shoots at host board
//   CHECK        |  5   | two cycles: read latency, then decide
//   GAME_OVER    |  6   | winner decided, outputs held until start

module game_turn_ctrl #(
  parameter int SHIPS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       click_host,
  input  logic       click_guest,
  input  logic [5:0] cursor_host,
  input  logic [5:0] cursor_guest,
  input  logic [1:0] cell_state,
  output logic       board_clr,
  output logic       board_sel,
  output logic [5:0] board_pos,
  output logic       board_wr,
  output logic [1:0] board_wdata,
  output logic [2:0] phase,
  output logic [3:0] hits_host,
  output logic [3:0] hits_guest,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PLACE_HOST  = 3'd1,
    PLACE_GUEST = 3'd2,
    TURN_HOST   = 3'd3,
    TURN_GUEST  = 3'd4,
    CHECK       = 3'd5,
    GAME_OVER   = 3'd6
  } state_t;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_SHIP  = 2'b01;
  localparam logic [1:0] CELL_HIT   = 2'b10;
  localparam logic [1:0] CELL_MISS  = 2'b11;

  localparam logic [3:0] SHIP_CNT = 4'(SHIPS);

  state_t     state, state_n;
  state_t     ret_state, ret_state_n;
  logic       check_late, check_late_n;   // second CHECK cycle: cell_state is valid
  logic [3:0] place_cnt, place_cnt_n;

  logic       board_clr_n, board_sel_n, board_wr_n;
  logic [5:0] board_pos_n;
  logic [1:0] board_wdata_n;
  logic [3:0] hits_host_n, hits_guest_n;
  logic [1:0] winner_n;

  logic       shooter_guest;
  state_t     other_turn;
  state_t     hit_turn;
  logic [3:0] hits_host_inc, hits_guest_inc;

  assign phase = state;

  assign shooter_guest = (ret_state == TURN_GUEST);
  assign other_turn    = shooter_guest ? TURN_HOST : TURN_GUEST;

`ifdef HIT_BONUS_EN
  assign hit_turn = ret_state;
`else
  assign hit_turn = other_turn;
`endif

  // The game ends as soon as a counter reaches SHIP_CNT, so saturation only
  // guards against a stray increment.
  assign hits_host_inc  = (hits_host  >= SHIP_CNT) ? hits_host  : hits_host  + 4'd1;
  assign hits_guest_inc = (hits_guest >= SHIP_CNT) ? hits_guest : hits_guest + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ret_state   <= IDLE;
      check_late  <= 1'b0;
      place_cnt   <= 4'd0;
      board_clr   <= 1'b0;
      board_sel   <= 1'b0;
      board_pos   <= 6'd0;
      board_wr    <= 1'b0;
      board_wdata <= CELL_EMPTY;
      hits_host   <= 4'd0;
      hits_guest  <= 4'd0;
      winner      <= 2'b00;
    end else begin
      state       <= state_n;
      ret_state   <= ret_state_n;
      check_late  <= check_late_n;
      place_cnt   <= place_cnt_n;
      board_clr   <= board_clr_n;
      board_sel   <= board_sel_n;
      board_pos   <= board_pos_n;
      board_wr    <= board_wr_n;
      board_wdata <= board_wdata_n;
      hits_host   <= hits_host_n;
      hits_guest  <= hits_guest_n;
      winner      <= winner_n;
    end
  end

  always_comb begin
    state_n       = state;
    ret_state_n   = ret_state;
    check_late_n  = 1'b0;
    place_cnt_n   = place_cnt;
    board_clr_n   = 1'b0;
    board_sel_n   = board_sel;
    board_pos_n   = board_pos;
    board_wr_n    = 1'b0;
    board_wdata_n = board_wdata;
    hits_host_n   = hits_host;
    hits_guest_n  = hits_guest;
    winner_n      = winner;

    unique case (state)
      IDLE, GAME_OVER: begin
        if (start) begin
          board_clr_n  = 1'b1;
          place_cnt_n  = 4'd0;
          hits_host_n  = 4'd0;
          hits_guest_n = 4'd0;
          winner_n     = 2'b00;
          state_n      = PLACE_HOST;
        end
      end

      PLACE_HOST: begin
        if (click_host) begin
          board_pos_n = cursor_host;
          board_sel_n = 1'b0;
          ret_state_n = PLACE_HOST;
          state_n     = CHECK;
        end
      end

      PLACE_GUEST: begin
        if (click_guest) begin
          board_pos_n = cursor_guest;
          board_sel_n = 1'b1;
          ret_state_n = PLACE_GUEST;
          state_n     = CHECK;
        end
      end

      // Shots address the opponent's board.
      TURN_HOST: begin
        if (click_host) begin
          board_pos_n = cursor_host;
          board_sel_n = 1'b1;
          ret_state_n = TURN_HOST;
          state_n     = CHECK;
        end
      end

      TURN_GUEST: begin
        if (click_guest) begin
          board_pos_n = cursor_guest;
          board_sel_n = 1'b0;
          ret_state_n = TURN_GUEST;
          state_n     = CHECK;
        end
      end

      CHECK: begin
        if (!check_late) begin
          check_late_n = 1'b1;
        end else begin
          state_n = ret_state;
          if (ret_state == PLACE_HOST || ret_state == PLACE_GUEST) begin
            // Only an empty cell accepts a ship; anything else is a rejected click.
            if (cell_state == CELL_EMPTY) begin
              board_wr_n    = 1'b1;
              board_wdata_n = CELL_SHIP;
              if (place_cnt + 4'd1 == SHIP_CNT) begin
                place_cnt_n = 4'd0;
                state_n     = (ret_state == PLACE_HOST) ? PLACE_GUEST : TURN_HOST;
              end else begin
                place_cnt_n = place_cnt + 4'd1;
              end
            end
          end else begin
            unique case (cell_state)
              CELL_SHIP: begin
                board_wr_n    = 1'b1;
                board_wdata_n = CELL_HIT;
                state_n       = hit_turn;
                if (shooter_guest) begin
                  hits_guest_n = hits_guest_inc;
                  if (hits_guest_inc == SHIP_CNT) begin
                    winner_n = 2'b10;
                    state_n  = GAME_OVER;
                  end
                end else begin
                  hits_host_n = hits_host_inc;
                  if (hits_host_inc == SHIP_CNT) begin
                    winner_n = 2'b01;
                    state_n  = GAME_OVER;
                  end
                end
              end
              CELL_EMPTY: begin
                board_wr_n    = 1'b1;
                board_wdata_n = CELL_MISS;
                state_n       = other_turn;
              end
              // Already-shot cell: no write, same shooter tries again.
              CELL_HIT, CELL_MISS: begin
                state_n = ret_state;
              end
              default: begin
                state_n = ret_state;
              end
            endcase
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Testbench for game_turn_ctrl: emulates the board memory, keeps a
// transaction-level game model and compares every cycle.
module tb_game_turn_ctrl;

  localparam int SHIPS = 4;

  localparam int P_IDLE = 0, P_PH = 1, P_PG = 2, P_TH = 3, P_TG = 4, P_CHK = 5, P_GO = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       click_host = 1'b0;
  logic       click_guest = 1'b0;
  logic [5:0] cursor_host = '0;
  logic [5:0] cursor_guest = '0;
  logic [1:0] cell_state = '0;
  logic       board_clr, board_sel, board_wr;
  logic [5:0] board_pos;
  logic [1:0] board_wdata;
  logic [2:0] phase;
  logic [3:0] hits_host, hits_guest;
  logic [1:0] winner;

  game_turn_ctrl #(.SHIPS(SHIPS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .click_host(click_host), .click_guest(click_guest),
    .cursor_host(cursor_host), .cursor_guest(cursor_guest),
    .cell_state(cell_state),
    .board_clr(board_clr), .board_sel(board_sel), .board_pos(board_pos),
    .board_wr(board_wr), .board_wdata(board_wdata), .phase(phase),
    .hits_host(hits_host), .hits_guest(hits_guest), .winner(winner)
  );

  always #5 clk = ~clk;

  // Board memory emulation with one-cycle read latency.
  logic [1:0] mem [2][64];
  always @(posedge clk) begin
    if (board_clr) begin
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 64; c++) mem[b][c] <= 2'b00;
    end else if (board_wr) begin
      mem[board_sel][board_pos] <= board_wdata;
    end
    cell_state <= mem[board_sel][board_pos];
  end

  // Game model.
  int         exp_phase = P_IDLE;
  int         exp_clr = 0, exp_wr = 0, exp_wdata = 0;
  int         exp_sel = 0, exp_pos = 0;
  int         exp_hh = 0, exp_hg = 0, exp_win = 0;
  int         place_cnt = 0;
  int         board_m [2][64];
  bit         chk_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("phase", 32'(phase), exp_phase);
      check("board_clr", 32'(board_clr), exp_clr);
      check("board_wr", 32'(board_wr), exp_wr);
      if (exp_wr != 0) check("board_wdata", 32'(board_wdata), exp_wdata);
      check("board_sel", 32'(board_sel), exp_sel);
      check("board_pos", 32'(board_pos), exp_pos);
      check("hits_host", 32'(hits_host), exp_hh);
      check("hits_guest", 32'(hits_guest), exp_hg);
      check("winner", 32'(winner), exp_win);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_phase = P_IDLE; exp_clr = 0; exp_wr = 0; exp_wdata = 0;
    exp_sel = 0; exp_pos = 0; exp_hh = 0; exp_hg = 0; exp_win = 0; place_cnt = 0;
  endtask

  task automatic do_start();
    bit ok;
    ok = (exp_phase == P_IDLE) || (exp_phase == P_GO);
    start = 1'b1;
    step();
    start = 1'b0;
    if (ok) begin
      exp_clr = 1; exp_phase = P_PH; exp_hh = 0; exp_hg = 0; exp_win = 0; place_cnt = 0;
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 64; c++) board_m[b][c] = 0;
      step();
      exp_clr = 0;
    end
  endtask

  // A click by host (g=0) or guest (g=1). With both=1 the other player clicks
  // in the same cycle on a different cell.
  task automatic click(input bit g, input int pos, input bit both);
    bit active, placing, tgt;
    int ret, other, cs;
    active = (!g && (exp_phase == P_PH || exp_phase == P_TH)) ||
             ( g && (exp_phase == P_PG || exp_phase == P_TG));
    if (g) begin click_guest = 1'b1; cursor_guest = 6'(pos); end
    else   begin click_host  = 1'b1; cursor_host  = 6'(pos); end
    if (both) begin
      if (g) begin click_host  = 1'b1; cursor_host  = 6'(pos ^ 63); end
      else   begin click_guest = 1'b1; cursor_guest = 6'(pos ^ 63); end
    end
    step();
    click_host = 1'b0; click_guest = 1'b0;
    if (!active) return;
    ret     = exp_phase;
    placing = (ret == P_PH || ret == P_PG);
    tgt     = placing ? g : !g;
    other   = (ret == P_TH) ? P_TG : P_TH;
    exp_sel = tgt; exp_pos = pos; exp_phase = P_CHK;
    // Everything during CHECK must be ignored and not queued.
    click_host = 1'b1; click_guest = 1'b1; start = 1'b1;
    step();
    click_host = 1'b0; click_guest = 1'b0; start = 1'b0;
    step();
    cs = board_m[tgt][pos];
    exp_phase = ret;
    if (placing) begin
      if (cs == 0) begin
        exp_wr = 1; exp_wdata = 1; board_m[tgt][pos] = 1;
        place_cnt++;
        if (place_cnt == SHIPS) begin
          place_cnt = 0;
          exp_phase = (ret == P_PH) ? P_PG : P_TH;
        end
      end
    end else if (cs == 1) begin
      exp_wr = 1; exp_wdata = 2; board_m[tgt][pos] = 2;
`ifdef HIT_BONUS_EN
      exp_phase = ret;
`else
      exp_phase = other;
`endif
      if (g) exp_hg++; else exp_hh++;
      if ((g ? exp_hg : exp_hh) == SHIPS) begin
        exp_phase = P_GO;
        exp_win = g ? 2 : 1;
      end
    end else if (cs == 0) begin
      exp_wr = 1; exp_wdata = 3; board_m[tgt][pos] = 3;
      exp_phase = other;
    end
    step();
    exp_wr = 0;
  endtask

  task automatic shoot(input int pos, input bit both);
    click(exp_phase == P_TG, pos, both);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int host_tgt [3];
    int hi, gk;
    host_tgt[0] = 6; host_tgt[1] = 7; host_tgt[2] = 8;
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < 64; c++) board_m[b][c] = 0;
    model_reset();
    rst = 1'b1;
    step(); step();
    check("rst_phase", 32'(phase), 0);
    check("rst_wr_clr", 32'({board_wr, board_clr}), 0);
    check("rst_wdata", 32'(board_wdata), 0);
    check("rst_winner", 32'(winner), 0);
    rst = 1'b0;
    chk_en = 1'b1;
    step();

    // Start and host placement.
    do_start();
    check("start_phase", 32'(phase), 1);
    click(1, 9, 0);                         // guest ignored in PLACE_HOST
    do_start();                             // start ignored in PLACE_HOST
    for (int i = 0; i < 4; i++) click(0, i, 0);
    check("placed_phase", 32'(phase), 2);

    // Guest placement with a rejected duplicate.
    click(1, 5, 0);
    click(1, 5, 0);
    click(1, 6, 0);
    click(1, 7, 0);
    check("guest_3_phase", 32'(phase), 2);  // only 3 ships so far
    click(1, 8, 0);
    check("turn_phase", 32'(phase), 3);

    // Shots.
    shoot(40, 0);                           // host miss
    shoot(10, 0);                           // guest miss
    shoot(5, 0);                            // host hit
    check("first_hit", 32'(hits_host), 1);
    if (exp_phase == P_TH) shoot(41, 0);    // bonus build: host keeps turn
    shoot(10, 1);                           // guest repeat shot, host clicks too
    check("repeat_phase", 32'(phase), 4);
    shoot(0, 0);                            // guest hit
    check("guest_hit", 32'(hits_guest), 1);

    hi = 0; gk = 0;
    for (int it = 0; it < 20 && exp_phase != P_GO; it++) begin
      if (exp_phase == P_TH) begin shoot(host_tgt[hi], 0); hi++; end
      else begin shoot(48 + gk, 0); gk++; end
    end
    check("win_phase", 32'(phase), 6);
    check("win_winner", 32'(winner), 1);
    check("win_hits", 32'(hits_host), 4);

    // Game over: clicks ignored, then restart.
    click(0, 20, 0);
    click(1, 21, 0);
    step();
    do_start();
    check("restart_phase", 32'(phase), 1);
    check("restart_winner", 32'(winner), 0);

    // Reset in the first CHECK cycle aborts the pending placement.
    click_host = 1'b1; cursor_host = 6'd12;
    step();
    click_host = 1'b0;
    exp_phase = P_CHK; exp_sel = 0; exp_pos = 12;
    rst = 1'b1;
    #1;
    check("rst_mid_check", 32'(phase), 0);
    model_reset();
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
